// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor.
// The FSM state encoding and the default operand width live here.
package serial_sub_pkg;

    localparam int SUB_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Start/busy/done handshake and operand/result bus
// for the serial subtraction controller.
interface serial_sub_ctrl_if
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SUB_W_DEFAULT
);

    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff_out;
    logic             borrow_out;

    modport master (
        output start, a_in, b_in,
        input  busy, done, diff_out, borrow_out
    );

    modport slave (
        input  start, a_in, b_in,
        output busy, done, diff_out, borrow_out
    );

endinterface

// File: rtl/serial_sub_cell.sv
// Combinational 1-bit full subtractor built
// from two half-subtractor stages.
module serial_sub_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    logic d1;
    logic bout1;
    logic bout2;

    assign d1     = a_i ^ b_i;
    assign bout1  = ~a_i & b_i;
    assign d_o    = d1 ^ bin_i;
    assign bout2  = ~d1 & bin_i;
    assign bout_o = bout1 | bout2;

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial a - b controller: one bit per clock, LSB first,
// reusing a single full-subtractor cell for wide operands.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SUB_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    serial_sub_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_sr_q, res_sr_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic cell_d;
    logic cell_bout;

    serial_sub_cell u_cell (
        .a_i    (a_sr_q[0]),
        .b_i    (b_sr_q[0]),
        .bin_i  (borrow_q),
        .d_o    (cell_d),
        .bout_o (cell_bout)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        borrow_d = borrow_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    state_d  = SHIFT;
                    a_sr_d   = bus.a_in;
                    b_sr_d   = bus.b_in;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                end
            end
            SHIFT: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                res_sr_d = {cell_d, res_sr_q[WIDTH-1:1]};
                borrow_d = cell_bout;
                cnt_d    = cnt_q + CNT_W'(1);
                // Last bit: publish result as we enter DONE
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    diff_d  = {cell_d, res_sr_q[WIDTH-1:1]};
                    bout_d  = cell_bout;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            borrow_q <= borrow_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
        end
    end

    assign bus.busy       = (state_q == SHIFT);
    assign bus.done       = (state_q == DONE);
    assign bus.diff_out   = diff_q;
    assign bus.borrow_out = bout_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl at WIDTH=8 and WIDTH=13,
// compared against plain wide-subtraction arithmetic.
module tb_serial_sub_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   last8 = -1;
    int   last13 = -1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    serial_sub_ctrl_if #(.WIDTH(8))  if8 ();
    serial_sub_ctrl_if #(.WIDTH(13)) if13 ();

    serial_sub_ctrl #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8)
    );

    serial_sub_ctrl #(.WIDTH(13)) dut13 (
        .clk (clk),
        .rst (rst),
        .bus (if13)
    );

    // Protocol monitor: exclusivity of busy/done and minimum done spacing
    always @(negedge clk) begin
        if (rst) begin
            last8  = -1;
            last13 = -1;
        end else begin
            vectors++;
            if (if8.busy && if8.done) begin
                miscompares++;
                $display("FAIL busy_done_excl_w8 busy=%0b done=%0b required not both", if8.busy, if8.done);
            end
            vectors++;
            if (if13.busy && if13.done) begin
                miscompares++;
                $display("FAIL busy_done_excl_w13 busy=%0b done=%0b required not both", if13.busy, if13.done);
            end
            if (if8.done) begin
                if (last8 >= 0) begin
                    vectors++;
                    if (cyc - last8 < 9) begin
                        miscompares++;
                        $display("FAIL done_spacing_w8 got=%0d required>=9", cyc - last8);
                    end
                end
                last8 = cyc;
            end
            if (if13.done) begin
                if (last13 >= 0) begin
                    vectors++;
                    if (cyc - last13 < 14) begin
                        miscompares++;
                        $display("FAIL done_spacing_w13 got=%0d required>=14", cyc - last13);
                    end
                end
                last13 = cyc;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b);
        return {1'b0, a} - {1'b0, b};
    endfunction

    function automatic logic [13:0] ref13(input logic [12:0] a, input logic [12:0] b);
        return {1'b0, a} - {1'b0, b};
    endfunction

    // Launch one 8-bit op and stop on the done cycle
    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       output logic [8:0] res, output int nbusy, output bit ok);
        if8.start = 1'b1;
        if8.a_in  = a;
        if8.b_in  = b;
        step();
        if8.start = 1'b0;
        if8.a_in  = 8'($urandom);
        if8.b_in  = 8'($urandom);
        nbusy = 0;
        ok    = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (if8.done) begin
                ok = 1'b1;
                break;
            end
            if (if8.busy) nbusy++;
            step();
        end
        res = {if8.borrow_out, if8.diff_out};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        vectors++;
        if (if8.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy got=%0b required=0", if8.busy);
        end
        vectors++;
        if (if8.done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_done got=%0b required=0", if8.done);
        end
        vectors++;
        if (if8.diff_out !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_diff got=%h required=00", if8.diff_out);
        end
        vectors++;
        if (if8.borrow_out !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_borrow got=%0b required=0", if8.borrow_out);
        end
        vectors++;
        if ({if13.busy, if13.done, if13.diff_out} !== 15'h0) begin
            miscompares++;
            $display("FAIL reset_w13 got=%h required=0", {if13.busy, if13.done, if13.diff_out});
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_directed();
        logic [7:0] av [4] = '{8'd200, 8'd5, 8'd0, 8'hAA};
        logic [7:0] bv [4] = '{8'd55, 8'd10, 8'd1, 8'hAA};
        logic [8:0] res;
        logic [8:0] exp;
        int nbusy;
        bit ok;
        for (int k = 0; k < 4; k++) begin
            op8(av[k], bv[k], res, nbusy, ok);
            exp = ref8(av[k], bv[k]);
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL directed_timeout op=%0d no done within 40 cycles", k);
            end
            vectors++;
            if (nbusy != 8) begin
                miscompares++;
                $display("FAIL directed_busy_cycles op=%0d got=%0d required=8", k, nbusy);
            end
            vectors++;
            if (res !== exp) begin
                miscompares++;
                $display("FAIL directed_result op=%0d got=%h required=%h", k, res, exp);
            end
            step();
            vectors++;
            if (if8.done !== 1'b0 || {if8.borrow_out, if8.diff_out} !== exp) begin
                miscompares++;
                $display("FAIL directed_after_done op=%0d done=%0b result=%h required done=0 result=%h",
                         k, if8.done, {if8.borrow_out, if8.diff_out}, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] res;
        int nbusy;
        int t0;
        bit ok;
        bit got;
        op8(8'hAA, 8'hAA, res, nbusy, ok);
        if8.start = 1'b1;
        if8.a_in  = 8'h10;
        if8.b_in  = 8'h01;
        t0 = cyc;
        step();
        if8.start = 1'b0;
        if8.a_in  = 8'hFF;
        if8.b_in  = 8'hFF;
        vectors++;
        if (if8.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_no_gap busy=%0b required=1", if8.busy);
        end
        vectors++;
        if ({if8.borrow_out, if8.diff_out} !== 9'h000) begin
            miscompares++;
            $display("FAIL b2b_held_result got=%h required=000", {if8.borrow_out, if8.diff_out});
        end
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (if8.done) begin
                got = 1'b1;
                break;
            end
            step();
        end
        vectors++;
        if (!got || cyc - t0 != 9) begin
            miscompares++;
            $display("FAIL b2b_latency got=%0d seen=%0b required=9", cyc - t0, got);
        end
        vectors++;
        if ({if8.borrow_out, if8.diff_out} !== ref8(8'h10, 8'h01)) begin
            miscompares++;
            $display("FAIL b2b_result got=%h required=%h",
                     {if8.borrow_out, if8.diff_out}, ref8(8'h10, 8'h01));
        end
        step();
    endtask

    task automatic test_busy_ignore();
        bit got;
        if8.start = 1'b1;
        if8.a_in  = 8'h3C;
        if8.b_in  = 8'h5A;
        step();
        if8.start = 1'b0;
        step();
        step();
        if8.start = 1'b1;
        if8.a_in  = 8'hFF;
        if8.b_in  = 8'h00;
        step();
        if8.start = 1'b0;
        if8.a_in  = 8'($urandom);
        if8.b_in  = 8'($urandom);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (if8.done) begin
                got = 1'b1;
                break;
            end
            step();
        end
        vectors++;
        if (!got || {if8.borrow_out, if8.diff_out} !== ref8(8'h3C, 8'h5A)) begin
            miscompares++;
            $display("FAIL busy_ignore_result seen=%0b got=%h required=%h",
                     got, {if8.borrow_out, if8.diff_out}, ref8(8'h3C, 8'h5A));
        end
        step();
        vectors++;
        if (if8.busy !== 1'b0 || if8.done !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_ignore_no_rerun busy=%0b done=%0b required 0 0", if8.busy, if8.done);
        end
    endtask

    task automatic test_abort();
        logic [8:0] res;
        int nbusy;
        bit ok;
        bit seen;
        op8(8'd5, 8'd10, res, nbusy, ok);
        step();
        if8.start = 1'b1;
        if8.a_in  = 8'h77;
        if8.b_in  = 8'h11;
        step();
        if8.start = 1'b0;
        repeat (3) step();
        vectors++;
        if (if8.busy !== 1'b1 || if8.diff_out !== 8'hFB) begin
            miscompares++;
            $display("FAIL abort_pre busy=%0b diff=%h required 1 fb", if8.busy, if8.diff_out);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        if ({if8.busy, if8.done, if8.borrow_out, if8.diff_out} !== 11'h0) begin
            miscompares++;
            $display("FAIL abort_clear got busy=%0b done=%0b borrow=%0b diff=%h required all 0",
                     if8.busy, if8.done, if8.borrow_out, if8.diff_out);
        end
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (if8.done) seen = 1'b1;
            step();
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL abort_no_done got done seen=1 required 0");
        end
        rst       = 1'b1;
        if8.start = 1'b1;
        step();
        rst       = 1'b0;
        if8.start = 1'b0;
        vectors++;
        if (if8.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_over_start busy=%0b required=0", if8.busy);
        end
        step();
    endtask

    task automatic test_random(input int n);
        logic [7:0]  a8, b8;
        logic [12:0] a13, b13;
        logic [8:0]  r8;
        logic [13:0] r13;
        bit g8, g13;
        for (int k = 0; k < n; k++) begin
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            a13 = 13'($urandom);
            b13 = 13'($urandom);
            if8.start  = 1'b1;
            if8.a_in   = a8;
            if8.b_in   = b8;
            if13.start = 1'b1;
            if13.a_in  = a13;
            if13.b_in  = b13;
            step();
            if8.start  = 1'b0;
            if13.start = 1'b0;
            if8.a_in   = 8'($urandom);
            if8.b_in   = 8'($urandom);
            if13.a_in  = 13'($urandom);
            if13.b_in  = 13'($urandom);
            g8  = 1'b0;
            g13 = 1'b0;
            r8  = '0;
            r13 = '0;
            for (int i = 0; i < 40 && !(g8 && g13); i++) begin
                if (if8.done && !g8) begin
                    g8 = 1'b1;
                    r8 = {if8.borrow_out, if8.diff_out};
                end
                if (if13.done && !g13) begin
                    g13 = 1'b1;
                    r13 = {if13.borrow_out, if13.diff_out};
                end
                step();
            end
            vectors++;
            if (!g8 || r8 !== ref8(a8, b8)) begin
                miscompares++;
                $display("FAIL random_w8 a=%h b=%h seen=%0b got=%h required=%h",
                         a8, b8, g8, r8, ref8(a8, b8));
            end
            vectors++;
            if (!g13 || r13 !== ref13(a13, b13)) begin
                miscompares++;
                $display("FAIL random_w13 a=%h b=%h seen=%0b got=%h required=%h",
                         a13, b13, g13, r13, ref13(a13, b13));
            end
            repeat ($urandom_range(0, 1)) step();
        end
    endtask

    initial begin
        rst        = 1'b1;
        if8.start  = 1'b0;
        if8.a_in   = '0;
        if8.b_in   = '0;
        if13.start = 1'b0;
        if13.a_in  = '0;
        if13.b_in  = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_busy_ignore();
        test_abort();
        test_random(1500);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
